rf_writeback_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources, the ALU result path and the memory-load path. It buffers each source's requests in a small FIFO and commits exactly one write per cycle in global arrival order. It drives the register file's write controls, with `PVSWriteEn` and `RegWrite` tied together from `rf_we`. It also exports a per-register pending mask so the control unit can stall readers of registers that still have uncommitted writes.

---
 rtl/rf_writeback_arbiter_pkg.sv | 20 ++
 rtl/rf_wb_fifo.sv | 82 ++++++++
 rtl/rf_writeback_arbiter.sv | 149 ++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared register-file definitions plus the writeback arbiter's source encoding
// and ticket sizing helper.
package rf_writeback_arbiter_pkg;

  localparam int WORD_SIZE = 16;
  localparam int REG_SIZE  = 4;
  localparam int RF_ADDR_W = 2;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wbSrc_e;

  // One extra bit over the outstanding-entry range keeps live tickets unambiguous.
  function automatic int ticketWidth(input int depth);
    return $clog2(2 * depth) + 1;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small per-source writeback queue: {reg, data, ticket} entries with a
// combinational head and a per-slot {valid, reg} view for hazard tracking.
module rf_wb_fifo
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int TICKET_W = 3
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               push,
  input  logic [RF_ADDR_W-1:0]               pushReg,
  input  logic [WORD_SIZE-1:0]               pushData,
  input  logic [TICKET_W-1:0]                pushTicket,
  input  logic                               pop,
  output logic                               full,
  output logic                               empty,
  output logic [RF_ADDR_W-1:0]               headReg,
  output logic [WORD_SIZE-1:0]               headData,
  output logic [TICKET_W-1:0]                headTicket,
  output logic [DEPTH-1:0]                   entryValid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]    entryReg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [RF_ADDR_W-1:0] regMem    [DEPTH];
  logic [WORD_SIZE-1:0] dataMem   [DEPTH];
  logic [TICKET_W-1:0]  ticketMem [DEPTH];

  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: slot validity is derived from the pointers.
  always_ff @(posedge clk) begin
    if (doPush) begin
      regMem[wrPtr]    <= pushReg;
      dataMem[wrPtr]   <= pushData;
      ticketMem[wrPtr] <= pushTicket;
    end
  end

  assign headReg    = regMem[rdPtr];
  assign headData   = dataMem[rdPtr];
  assign headTicket = ticketMem[rdPtr];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gSlot
      logic [PTR_W-1:0] offset;
      assign offset         = PTR_W'(gi) - rdPtr;
      assign entryValid[gi] = (CNT_W'(offset) < count);
      assign entryReg[gi]   = regMem[gi];
    end
  endgenerate

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the register file write port between the ALU and load writeback paths,
// committing one queued write per cycle in global arrival order.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TICKET_W   = ticketWidth(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [RF_ADDR_W-1:0] alu_reg,
  input  logic [WORD_SIZE-1:0] alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [RF_ADDR_W-1:0] mem_reg,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 commit_en,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [WORD_SIZE-1:0] rf_wdata,
  output logic [REG_SIZE-1:0]  pending,
  output logic                 busy
);

  logic [TICKET_W-1:0] issueCtr;
  logic [TICKET_W-1:0] serveCtr;

  logic aluPush, memPush, aluPop, memPop;
  logic aluFull, aluEmpty, memFull, memEmpty;
  logic aluElig, memElig;
  logic [TICKET_W-1:0] aluTicket, memTicket;

  logic [RF_ADDR_W-1:0] aluHeadReg, memHeadReg;
  logic [WORD_SIZE-1:0] aluHeadData, memHeadData;
  logic [TICKET_W-1:0]  aluHeadTicket, memHeadTicket;

  logic [FIFO_DEPTH-1:0]                aluEntryValid, memEntryValid;
  logic [FIFO_DEPTH-1:0][RF_ADDR_W-1:0] aluEntryReg, memEntryReg;

  wbSrc_e commitSrc;

  assign alu_ready = !aluFull;
  assign mem_ready = !memFull;
  assign aluPush   = alu_valid && alu_ready;
  assign memPush   = mem_valid && mem_ready;

  // A simultaneous pair is ordered MEM first, ALU second.
  assign memTicket = issueCtr;
  assign aluTicket = memPush ? issueCtr + 1'b1 : issueCtr;

  rf_wb_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .TICKET_W (TICKET_W)
  ) uAluFifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (aluPush),
    .pushReg    (alu_reg),
    .pushData   (alu_data),
    .pushTicket (aluTicket),
    .pop        (aluPop),
    .full       (aluFull),
    .empty      (aluEmpty),
    .headReg    (aluHeadReg),
    .headData   (aluHeadData),
    .headTicket (aluHeadTicket),
    .entryValid (aluEntryValid),
    .entryReg   (aluEntryReg)
  );

  rf_wb_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .TICKET_W (TICKET_W)
  ) uMemFifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (memPush),
    .pushReg    (mem_reg),
    .pushData   (mem_data),
    .pushTicket (memTicket),
    .pop        (memPop),
    .full       (memFull),
    .empty      (memEmpty),
    .headReg    (memHeadReg),
    .headData   (memHeadData),
    .headTicket (memHeadTicket),
    .entryValid (memEntryValid),
    .entryReg   (memEntryReg)
  );

  assign aluElig = !aluEmpty && (aluHeadTicket == serveCtr);
  assign memElig = !memEmpty && (memHeadTicket == serveCtr);

  always_comb begin
    commitSrc = SRC_NONE;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    aluPop    = 1'b0;
    memPop    = 1'b0;
    if (commit_en) begin
      if (aluElig)      commitSrc = SRC_ALU;
      else if (memElig) commitSrc = SRC_MEM;
    end
    case (commitSrc)
      SRC_ALU: begin
        rf_we    = 1'b1;
        rf_waddr = aluHeadReg;
        rf_wdata = aluHeadData;
        aluPop   = 1'b1;
      end
      SRC_MEM: begin
        rf_we    = 1'b1;
        rf_waddr = memHeadReg;
        rf_wdata = memHeadData;
        memPop   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issueCtr <= '0;
      serveCtr <= '0;
    end else begin
      issueCtr <= issueCtr + TICKET_W'(aluPush) + TICKET_W'(memPush);
      if (rf_we) serveCtr <= serveCtr + 1'b1;
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < REG_SIZE; gi++) begin : gPend
      logic [FIFO_DEPTH-1:0] aluHit;
      logic [FIFO_DEPTH-1:0] memHit;
      for (gj = 0; gj < FIFO_DEPTH; gj++) begin : gEntry
        assign aluHit[gj] = aluEntryValid[gj] && (aluEntryReg[gj] == RF_ADDR_W'(gi));
        assign memHit[gj] = memEntryValid[gj] && (memEntryReg[gj] == RF_ADDR_W'(gi));
      end
      assign pending[gi] = (|aluHit) || (|memHit);
    end
  endgenerate

  assign busy = !aluEmpty || !memEmpty;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed and scoreboarded checks of the writeback arbiter: ordering, backpressure,
// pending mask, asynchronous reset and ticket wrap.
module tb_rf_writeback_arbiter;
  import rf_writeback_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, mem_valid, commit_en;
  logic        alu_ready, mem_ready;
  logic [1:0]  alu_reg, mem_reg;
  logic [15:0] alu_data, mem_data;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [3:0]  pending;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int commits = 0;
  logic [15:0] rfModel [4];

  typedef struct {
    logic        isAlu;
    logic [1:0]  r;
    logic [15:0] d;
  } ent_t;
  ent_t expQ[$];

  rf_writeback_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_reg   (mem_reg),
    .mem_data  (mem_data),
    .commit_en (commit_en),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Register file as seen by the consumer of the write port.
  always @(posedge clk) begin
    if (rf_we) begin
      rfModel[rf_waddr] <= rf_wdata;
      commits <= commits + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
  task automatic cyc(input logic av, input logic [1:0] ar, input logic [15:0] ad,
                     input logic mv, input logic [1:0] mr, input logic [15:0] md,
                     input logic ce);
    @(negedge clk);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    commit_en = ce;
    #1;
  endtask

  task automatic idle(input logic ce);
    cyc(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, ce);
  endtask

  initial begin
    int base;
    int accepted;
    int iter;
    logic av, mv, ce, aAcc, mAcc;
    logic [1:0] ar, mr;
    logic [15:0] ad, md;
    ent_t e;
    int aluCnt, memCnt;

    for (int i = 0; i < 4; i++) rfModel[i] = 16'h0;
    reset_n = 1'b0;
    alu_valid = 0; mem_valid = 0; alu_reg = 0; mem_reg = 0;
    alu_data = 0; mem_data = 0; commit_en = 1'b1;
    #2;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single ALU write to R2
    cyc(1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 16'h0, 1'b1);
    chk("t1_we_before", 32'(rf_we), 32'd0);
    idle(1'b1);
    chk("t1_pending", 32'(pending), 32'b0100);
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_waddr", 32'(rf_waddr), 32'd2);
    chk("t1_wdata", 32'(rf_wdata), 32'h1234);
    idle(1'b1);
    chk("t1_we_after", 32'(rf_we), 32'd0);
    chk("t1_pending_after", 32'(pending), 32'd0);
    chk("t1_r2", 32'(rfModel[2]), 32'h1234);

    // 2: simultaneous same-register writes, MEM first
    cyc(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd1, 16'h5555, 1'b1);
    idle(1'b1);
    chk("t2_we0", 32'(rf_we), 32'd1);
    chk("t2_waddr0", 32'(rf_waddr), 32'd1);
    chk("t2_wdata0", 32'(rf_wdata), 32'h5555);
    idle(1'b1);
    chk("t2_we1", 32'(rf_we), 32'd1);
    chk("t2_wdata1", 32'(rf_wdata), 32'hAAAA);
    idle(1'b1);
    chk("t2_we_after", 32'(rf_we), 32'd0);
    chk("t2_r1", 32'(rfModel[1]), 32'hAAAA);

    // 3: backpressure with commit disabled
    cyc(1'b1, 2'd3, 16'h0001, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t3_ready0", 32'(alu_ready), 32'd1);
    cyc(1'b1, 2'd3, 16'h0002, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t3_ready1", 32'(alu_ready), 32'd1);
    cyc(1'b1, 2'd3, 16'h0003, 1'b0, 2'd0, 16'h0, 1'b0);
    chk("t3_ready_full", 32'(alu_ready), 32'd0);
    chk("t3_we_held", 32'(rf_we), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    cyc(1'b1, 2'd3, 16'h0003, 1'b0, 2'd0, 16'h0, 1'b1);
    chk("t3_ready_pop", 32'(alu_ready), 32'd0);
    chk("t3_wdata0", 32'(rf_wdata), 32'h0001);
    cyc(1'b1, 2'd3, 16'h0003, 1'b0, 2'd0, 16'h0, 1'b1);
    chk("t3_ready_back", 32'(alu_ready), 32'd1);
    chk("t3_wdata1", 32'(rf_wdata), 32'h0002);
    idle(1'b1);
    chk("t3_we2", 32'(rf_we), 32'd1);
    chk("t3_wdata2", 32'(rf_wdata), 32'h0003);
    chk("t3_busy_last", 32'(busy), 32'd1);
    idle(1'b1);
    chk("t3_busy_done", 32'(busy), 32'd0);
    chk("t3_we_done", 32'(rf_we), 32'd0);

    // 4: interleaved arrivals
    cyc(1'b1, 2'd0, 16'h0A0A, 1'b0, 2'd0, 16'h0, 1'b1);
    cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 16'h0B0B, 1'b1);
    chk("t4_waddr0", 32'(rf_waddr), 32'd0);
    chk("t4_wdata0", 32'(rf_wdata), 32'h0A0A);
    cyc(1'b1, 2'd0, 16'h0C0C, 1'b0, 2'd0, 16'h0, 1'b1);
    chk("t4_waddr1", 32'(rf_waddr), 32'd3);
    chk("t4_wdata1", 32'(rf_wdata), 32'h0B0B);
    idle(1'b1);
    chk("t4_waddr2", 32'(rf_waddr), 32'd0);
    chk("t4_wdata2", 32'(rf_wdata), 32'h0C0C);
    idle(1'b1);
    chk("t4_r0", 32'(rfModel[0]), 32'h0C0C);
    chk("t4_r3", 32'(rfModel[3]), 32'h0B0B);

    // 5: asynchronous reset discards queued writes
    cyc(1'b1, 2'd1, 16'h0011, 1'b1, 2'd2, 16'h0022, 1'b0);
    cyc(1'b1, 2'd3, 16'h0033, 1'b0, 2'd0, 16'h0, 1'b0);
    idle(1'b0);
    chk("t5_pending", 32'(pending), 32'b1110);
    commit_en = 1'b1;
    #1;
    chk("t5_we_pre", 32'(rf_we), 32'd1);
    base = commits;
    reset_n = 1'b0;
    #1;
    chk("t5_we_rst", 32'(rf_we), 32'd0);
    chk("t5_pending_rst", 32'(pending), 32'd0);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_ready_rst", 32'(alu_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t5_no_writes", 32'(commits - base), 32'd0);

    // 6: random traffic with ticket wrap against a scoreboard
    base = commits;
    accepted = 0;
    aluCnt = 0;
    memCnt = 0;
    iter = 0;
    while ((accepted < 40 || expQ.size() > 0) && iter < 400) begin
      iter++;
      av = (accepted < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      mv = (accepted < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (accepted == 39 && av && mv) av = 1'b0;
      ce = (accepted < 40) ? ($urandom_range(0, 3) != 0) : 1'b1;
      ar = 2'($urandom_range(0, 3));
      mr = 2'($urandom_range(0, 3));
      ad = 16'($urandom);
      md = 16'($urandom);
      cyc(av, ar, ad, mv, mr, md, ce);
      chk("t6_alu_ready", 32'(alu_ready), 32'(aluCnt < 2));
      chk("t6_mem_ready", 32'(mem_ready), 32'(memCnt < 2));
      aAcc = av && (aluCnt < 2);
      mAcc = mv && (memCnt < 2);
      if (ce && expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("t6_we", 32'(rf_we), 32'd1);
        chk("t6_waddr", 32'(rf_waddr), 32'(e.r));
        chk("t6_wdata", 32'(rf_wdata), 32'(e.d));
        if (e.isAlu) aluCnt--; else memCnt--;
      end else begin
        chk("t6_we_idle", 32'(rf_we), 32'd0);
      end
      if (mAcc) begin
        expQ.push_back('{isAlu: 1'b0, r: mr, d: md});
        memCnt++;
        accepted++;
      end
      if (aAcc) begin
        expQ.push_back('{isAlu: 1'b1, r: ar, d: ad});
        aluCnt++;
        accepted++;
      end
    end
    idle(1'b1);
    chk("t6_drained", 32'(expQ.size()), 32'd0);
    chk("t6_commits", 32'(commits - base), 32'd40);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
